// File: rtl/rv_core_pkg.sv
// rv_core_pkg: shared core widths, register-file geometry and clear-engine state encoding
package rv_core_pkg;
  localparam int XLEN = 64;
  localparam int NREGS = 32;
  localparam int AW = $clog2(NREGS);
  localparam int X0 = 0;
  typedef enum logic {CLEAR, READY} clr_state_e;
endpackage

// File: rtl/gpr_clear_fsm.sv
// gpr_clear_fsm: sweeps x1..xN-1 to zero one register per cycle after reset or on request
module gpr_clear_fsm import rv_core_pkg::*; #(
  parameter int N = NREGS,
  localparam int W = $clog2(N)
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         clr_req,
  output logic         rf_ready,
  output logic         clr_we,
  output logic [W-1:0] clr_addr
);
  clr_state_e state;
  logic [W-1:0] ptr;
  // sweep pointer advances every CLEAR edge; x0 is skipped since it is never stored
  always_ff @(posedge CLK)
    if (reset) begin
      state <= CLEAR;
      ptr <= W'(1);
    end else if (state == CLEAR) begin
      state <= ptr == W'(N - 1) ? READY : CLEAR;
      ptr <= ptr + W'(1);
    end else if (clr_req) begin
      state <= CLEAR;
      ptr <= W'(1);
    end
  assign rf_ready = state == READY;
  assign clr_we = state == CLEAR;
  assign clr_addr = ptr;
endmodule

// File: rtl/gpr_file_sb.sv
// gpr_file_sb: register file with hardwired x0, two write-back ports, optional bypass and busy scoreboard
module gpr_file_sb #(
  parameter int XLEN = rv_core_pkg::XLEN,
  parameter int NREGS = rv_core_pkg::NREGS,
  parameter int NUM_RD = 2,
  parameter bit BYPASS = 1'b1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   clr_req,
  output logic                   rf_ready,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   wb0_en,
  input  logic [AW-1:0]          wb0_dr,
  input  logic [XLEN-1:0]        wb0_data,
  input  logic                   wb1_en,
  input  logic [AW-1:0]          wb1_dr,
  input  logic [XLEN-1:0]        wb1_data,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_dr
);
  logic clr_we, upd, wr0, wr1;
  logic [AW-1:0] clr_addr;
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy, busy_set, busy_clr;
  gpr_clear_fsm #(.N(NREGS)) u_clr (
    .CLK(CLK), .reset(reset), .clr_req(clr_req),
    .rf_ready(rf_ready), .clr_we(clr_we), .clr_addr(clr_addr)
  );
  assign upd = rf_ready && !clr_req && !reset;
  assign wr0 = wb0_en && wb0_dr != AW'(rv_core_pkg::X0);
  assign wr1 = wb1_en && wb1_dr != AW'(rv_core_pkg::X0);
  assign busy_set = iss_en ? NREGS'(1) << iss_dr : '0;
  assign busy_clr = (wb0_en ? NREGS'(1) << wb0_dr : '0) | (wb1_en ? NREGS'(1) << wb1_dr : '0);
  // storage: sweep zeroes in CLEAR, write-back in READY with WB1 ordered last so it wins
  always_ff @(posedge CLK) begin
    if (clr_we) regs[clr_addr] <= '0;
    if (upd && wr0) regs[wb0_dr] <= wb0_data;
    if (upd && wr1) regs[wb1_dr] <= wb1_data;
  end
  // scoreboard: issue set applied after write-back clear so the younger issue wins; x0 never busy
  always_ff @(posedge CLK)
    busy <= upd ? ((busy & ~busy_clr) | busy_set) & ~NREGS'(1) : '0;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[k*AW +: AW];
    assign rd_busy[k] = busy[a];
    assign rd_data[k*XLEN +: XLEN] = !rf_ready || a == AW'(rv_core_pkg::X0) ? '0 :
                                     BYPASS && wr1 && wb1_dr == a ? wb1_data :
                                     BYPASS && wr0 && wb0_dr == a ? wb0_data : regs[a];
  end
endmodule

// File: tb/tb_gpr_file_sb.sv
// tb_gpr_file_sb: directed scoreboard bench for the register file and its clear engine
module tb_gpr_file_sb;
  localparam int XLEN = 64;
  localparam int AW = 5;
  localparam bit BYPASS = 1'b1;
  typedef struct { string tag; logic [63:0] v; } exp_t;
  logic CLK = 0, reset = 1, clr_req = 0, rf_ready;
  logic [2*AW-1:0] rd_addr = '0;
  logic [2*XLEN-1:0] rd_data;
  logic [1:0] rd_busy;
  logic wb0_en = 0, wb1_en = 0, iss_en = 0;
  logic [AW-1:0] wb0_dr = '0, wb1_dr = '0, iss_dr = '0;
  logic [XLEN-1:0] wb0_data = '0, wb1_data = '0;
  exp_t sb[$];
  int n_assert = 0, n_fail = 0;
  gpr_file_sb #(.XLEN(XLEN), .NREGS(32), .NUM_RD(2), .BYPASS(BYPASS)) dut (
    .CLK(CLK), .reset(reset), .clr_req(clr_req), .rf_ready(rf_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wb0_en(wb0_en), .wb0_dr(wb0_dr), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_dr(wb1_dr), .wb1_data(wb1_data),
    .iss_en(iss_en), .iss_dr(iss_dr)
  );
  always #5 CLK = ~CLK;
  task automatic push(input string t, input logic [63:0] v);
    exp_t e;
    e.tag = t;
    e.v = v;
    sb.push_back(e);
  endtask
  task automatic cmp(input logic [63:0] o);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h required an entry", o);
    end else begin
      e = sb.pop_front();
      assert (o === e.v) else begin
        n_fail++;
        $error("FAIL %s: observed %h required %h", e.tag, o, e.v);
      end
    end
  endtask
  task automatic rd0(input logic [AW-1:0] a);
    rd_addr[AW-1:0] = a;
  endtask
  task automatic rd1(input logic [AW-1:0] a);
    rd_addr[2*AW-1:AW] = a;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(posedge CLK);
    #1;
    push("reset_ready", 0); cmp(64'(rf_ready));
    push("reset_busy", 0); cmp(64'(rd_busy));
    reset = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge CLK);
      push($sformatf("init_ready_c%0d", i), 64'(i == 32)); cmp(64'(rf_ready));
    end
    for (int r = 1; r < 32; r++) begin
      rd0(AW'(r)); rd1(AW'(r));
      #1;
      push($sformatf("init_x%0d", r), 0); cmp(rd_data[63:0]);
      push($sformatf("init_busy_x%0d", r), 0); cmp(64'(rd_busy));
    end
    @(negedge CLK);
    wb0_en = 1; wb0_dr = 5; wb0_data = 64'hDEAD_BEEF; rd0(5);
    #1;
    push("bypass_x5", BYPASS ? 64'hDEAD_BEEF : 64'h0); cmp(rd_data[63:0]);
    @(negedge CLK);
    wb0_en = 0;
    #1;
    push("stored_x5", 64'hDEAD_BEEF); cmp(rd_data[63:0]);
    @(negedge CLK);
    wb0_en = 1; wb0_dr = 7; wb0_data = 1; wb1_en = 1; wb1_dr = 7; wb1_data = 2; rd0(7); rd1(7);
    #1;
    push("same_dr_bypass_x7", BYPASS ? 64'h2 : 64'h0); cmp(rd_data[63:0]);
    @(negedge CLK);
    wb1_en = 0; wb0_dr = 0; wb0_data = 64'hFF; iss_en = 1; iss_dr = 0; rd0(0);
    #1;
    push("x0_bypass", 0); cmp(rd_data[63:0]);
    push("wb1_wins_x7", 64'h2); cmp(rd_data[127:64]);
    @(negedge CLK);
    wb0_en = 0; iss_en = 0;
    #1;
    push("x0_stored", 0); cmp(rd_data[63:0]);
    push("x0_busy", 0); cmp(64'(rd_busy[0]));
    @(negedge CLK);
    iss_en = 1; iss_dr = 9; rd0(9);
    #1;
    push("busy9_not_bypassed", 0); cmp(64'(rd_busy[0]));
    @(negedge CLK);
    wb0_en = 1; wb0_dr = 9; wb0_data = 64'h99;
    #1;
    push("busy9_issued", 1); cmp(64'(rd_busy[0]));
    @(negedge CLK);
    iss_en = 0; wb0_en = 0; wb1_en = 1; wb1_dr = 9; wb1_data = 64'h11;
    #1;
    push("busy9_set_wins", 1); cmp(64'(rd_busy[0]));
    @(negedge CLK);
    wb1_en = 0;
    #1;
    push("busy9_cleared", 0); cmp(64'(rd_busy[0]));
    push("x9_data", 64'h11); cmp(rd_data[63:0]);
    @(negedge CLK);
    wb0_en = 1; wb0_dr = 3; wb0_data = 5; iss_en = 1; iss_dr = 4;
    @(negedge CLK);
    wb0_en = 0; iss_en = 0; rd0(3); rd1(4);
    #1;
    push("pre_clr_x3", 5); cmp(rd_data[63:0]);
    push("pre_clr_busy4", 1); cmp(64'(rd_busy[1]));
    @(negedge CLK);
    clr_req = 1; wb0_en = 1; wb0_dr = 3; wb0_data = 64'h77;
    #1;
    push("clr_req_ready", 1); cmp(64'(rf_ready));
    for (int i = 1; i <= 32; i++) begin
      @(negedge CLK);
      clr_req = 0;
      wb0_en = i <= 30; iss_en = i <= 30;
      #1;
      push($sformatf("sweep_ready_c%0d", i), 64'(i == 32)); cmp(64'(rf_ready));
      if (i == 5 || i == 20) begin
        push($sformatf("sweep_data_c%0d", i), 0); cmp(rd_data[63:0]);
        push($sformatf("sweep_busy_c%0d", i), 0); cmp(64'(rd_busy[1]));
      end
    end
    push("post_clr_x3", 0); cmp(rd_data[63:0]);
    push("post_clr_busy4", 0); cmp(64'(rd_busy[1]));
    rd0(5);
    #1;
    push("post_clr_x5", 0); cmp(rd_data[63:0]);
    @(negedge CLK);
    clr_req = 1;
    @(negedge CLK);
    clr_req = 0;
    repeat (9) @(negedge CLK);
    reset = 1;
    @(negedge CLK);
    reset = 0;
    for (int i = 1; i <= 32; i++) begin
      if (i > 1) @(negedge CLK);
      #1;
      push($sformatf("restart_ready_c%0d", i), 64'(i == 32)); cmp(64'(rf_ready));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
